// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   REG_INDEX_SIZE : width of an architectural register index (x0..x31)
//   reg_index_t    : register index type used on every index port
//   phc_state_e    : data-memory sequencer states (PHC_RUN / PHC_DWAIT)
package pipe_hazard_ctrl_pkg;

    localparam int REG_INDEX_SIZE = 5;

    typedef logic [REG_INDEX_SIZE-1:0] reg_index_t;

    typedef enum logic {
        PHC_RUN   = 1'b0,
        PHC_DWAIT = 1'b1
    } phc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Pure comparator: does a source operand of the ID instruction read the
// destination register of an older in-flight instruction?
//   rd_en_i / rd_index_i : older instruction writes rd_index_i
//   rs_en_i / rs_index_i : ID instruction reads rs_index_i
//   match_o              : 1 when both are enabled, indices equal, and rd != x0
module hazard_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       rd_en_i,
    input  reg_index_t rd_index_i,
    input  logic       rs_en_i,
    input  reg_index_t rs_index_i,
    output logic       match_o
);

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    assign match_o = (rd_index_i != '0) & (rs_index_i == rd_index_i) & rs_en_i & rd_en_i;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Detects load-use and branch-on-load hazards, sequences multi-cycle data
// memory accesses and fetch waits, discards wrong-path fetches after an ID
// redirect, and counts ID stall cycles.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   ctrl_id_*                : ID-stage instruction info (valid, jump/branch, sources)
//   ctrl_id2ex_* / ex2mem_*  : EX / MEM destination and load flag
//   ctrl_redirect_i          : ID resolved a taken jump/branch
//   ctrl_if_valid_i          : instruction memory delivers the fetch this cycle
//   ctrl_dmem_req_i/ready_i  : data memory access request / completion
//   ctrl_cnt_clr_i           : synchronous clear of the stall counter
//   ctrl_stall_*_o           : hold PC / if2id / id2ex / ex2mem
//   ctrl_flush_*_o           : load a bubble into if2id / id2ex / mem2wb
//   ctrl_pc_redirect_o       : PC takes the ID target this cycle
//   ctrl_stall_cnt_o         : saturating ID stall-cycle count
//   dbg_state_o, dbg_kill_pend_o : internal state for observation
//
// Data-memory handshake: ctrl_dmem_req_i is sampled only in PHC_RUN and starts
// an access; once in PHC_DWAIT, the access completes in the first cycle
// ctrl_dmem_ready_i is high, and the MEM instruction advances in that same
// cycle. Both inputs are ignored in the state where they carry no meaning.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_id_valid_i,
    input  logic             ctrl_inst_jump_i,
    input  logic             ctrl_inst_branch_i,
    input  logic             ctrl_id_rs1_en_i,
    input  logic             ctrl_id_rs2_en_i,
    input  reg_index_t       ctrl_id_rs1_index_i,
    input  reg_index_t       ctrl_id_rs2_index_i,
    input  logic             ctrl_id2ex_rd_en_i,
    input  reg_index_t       ctrl_id2ex_rd_index_i,
    input  logic             ctrl_id2ex_load_i,
    input  logic             ctrl_ex2mem_rd_en_i,
    input  reg_index_t       ctrl_ex2mem_rd_index_i,
    input  logic             ctrl_ex2mem_load_i,
    input  logic             ctrl_redirect_i,
    input  logic             ctrl_if_valid_i,
    input  logic             ctrl_dmem_req_i,
    input  logic             ctrl_dmem_ready_i,
    input  logic             ctrl_cnt_clr_i,
    output logic             ctrl_stall_if_o,
    output logic             ctrl_stall_id_o,
    output logic             ctrl_stall_ex_o,
    output logic             ctrl_stall_mem_o,
    output logic             ctrl_flush_if2id_o,
    output logic             ctrl_flush_id2ex_o,
    output logic             ctrl_flush_mem2wb_o,
    output logic             ctrl_pc_redirect_o,
    output logic [CNT_W-1:0] ctrl_stall_cnt_o,
    output phc_state_e       dbg_state_o,
    output logic             dbg_kill_pend_o
);

    phc_state_e       state_q, state_d;
    logic             kill_pend_q, kill_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_rs1_match, ex_rs2_match, mem_rs1_match, mem_rs2_match;
    logic dstall, luhaz, brhaz, stall_id, kill_now, pc_redirect;

    hazard_match u_match_ex_rs1 (
        .rd_en_i   (ctrl_id2ex_rd_en_i),
        .rd_index_i(ctrl_id2ex_rd_index_i),
        .rs_en_i   (ctrl_id_rs1_en_i),
        .rs_index_i(ctrl_id_rs1_index_i),
        .match_o   (ex_rs1_match)
    );

    hazard_match u_match_ex_rs2 (
        .rd_en_i   (ctrl_id2ex_rd_en_i),
        .rd_index_i(ctrl_id2ex_rd_index_i),
        .rs_en_i   (ctrl_id_rs2_en_i),
        .rs_index_i(ctrl_id_rs2_index_i),
        .match_o   (ex_rs2_match)
    );

    hazard_match u_match_mem_rs1 (
        .rd_en_i   (ctrl_ex2mem_rd_en_i),
        .rd_index_i(ctrl_ex2mem_rd_index_i),
        .rs_en_i   (ctrl_id_rs1_en_i),
        .rs_index_i(ctrl_id_rs1_index_i),
        .match_o   (mem_rs1_match)
    );

    hazard_match u_match_mem_rs2 (
        .rd_en_i   (ctrl_ex2mem_rd_en_i),
        .rd_index_i(ctrl_ex2mem_rd_index_i),
        .rs_en_i   (ctrl_id_rs2_en_i),
        .rs_index_i(ctrl_id_rs2_index_i),
        .match_o   (mem_rs2_match)
    );

    always_comb begin
        // Registered memory: the request cycle itself is already a stall.
        dstall = (state_q == PHC_RUN) ? ctrl_dmem_req_i : ~ctrl_dmem_ready_i;

        luhaz = ctrl_id_valid_i & ctrl_id2ex_load_i & (ex_rs1_match | ex_rs2_match);

        // jal/jalr only read rs1; a conditional branch compares rs1 and rs2.
        brhaz = ctrl_id_valid_i & ctrl_ex2mem_load_i &
                (((ctrl_inst_jump_i | ctrl_inst_branch_i) & mem_rs1_match) |
                 (ctrl_inst_branch_i & mem_rs2_match));

        stall_id    = dstall | luhaz | brhaz;
        pc_redirect = ctrl_redirect_i & ctrl_id_valid_i & ~stall_id;
        kill_now    = kill_pend_q & ctrl_if_valid_i;

        ctrl_stall_mem_o    = dstall;
        ctrl_stall_ex_o     = dstall;
        ctrl_stall_id_o     = stall_id;
        ctrl_stall_if_o     = stall_id | ~ctrl_if_valid_i;
        ctrl_flush_mem2wb_o = dstall;
        // Under a memory stall id2ex is held, so no bubble is inserted there.
        ctrl_flush_id2ex_o  = ~dstall & (luhaz | brhaz);
        ctrl_flush_if2id_o  = ~stall_id & (pc_redirect | ~ctrl_if_valid_i | kill_now);
        ctrl_pc_redirect_o  = pc_redirect;

        state_d = state_q;
        case (state_q)
            PHC_RUN:   if (ctrl_dmem_req_i)   state_d = PHC_DWAIT;
            PHC_DWAIT: if (ctrl_dmem_ready_i) state_d = PHC_RUN;
            default:                          state_d = PHC_RUN;
        endcase

        // A redirect while the fetch is still outstanding leaves a wrong-path
        // instruction in flight; drop it when it arrives. Set wins over clear.
        kill_pend_d = kill_pend_q;
        if (pc_redirect & ~ctrl_if_valid_i) begin
            kill_pend_d = 1'b1;
        end else if (kill_now & ~stall_id) begin
            kill_pend_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (ctrl_cnt_clr_i) begin
            stall_cnt_d = '0;
        end else if (stall_id & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PHC_RUN;
            kill_pend_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            kill_pend_q <= kill_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_stall_cnt_o = stall_cnt_q;
    assign dbg_state_o      = state_q;
    assign dbg_kill_pend_o  = kill_pend_q;

endmodule
